// File: rtl/spi_status_tx.sv
// SPI slave MISO transmitter: shifts a snapshot of status words out to the MCU
// while it clocks control words in. CS and SCK are oversampled in the i_Clock domain.
// Ports:
//   i_Clock, i_Reset    system clock, synchronous active-high reset
//   i_SPI_CS            chip select from the MCU, active low, asynchronous
//   i_SPI_Clock         SCK from the MCU, mode 0, asynchronous
//   i_Status            status words, word 0 in [15:0], sent first
//   o_SPI_Data          MISO, MSB first
//   o_Busy              high while a frame is in progress
//   o_Frame_Done        one-cycle pulse when CS deasserts at the end of a frame
//   o_Short_Frame       with o_Frame_Done: bit count differs from NUM_WORDS*16
//   o_Bit_Count         SCK rising edges seen in the last frame
module spi_status_tx #(
  parameter int NUM_WORDS   = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  input  logic                    i_SPI_CS,
  input  logic                    i_SPI_Clock,
  input  logic [NUM_WORDS*16-1:0] i_Status,
  output logic                    o_SPI_Data,
  output logic                    o_Busy,
  output logic                    o_Frame_Done,
  output logic                    o_Short_Frame,
  output logic [15:0]             o_Bit_Count
);

  // One spare code so the index can step past the last word without wrapping.
  localparam int WW = $clog2(NUM_WORDS + 2);
  localparam logic [15:0] FULL_BITS = 16'(NUM_WORDS * 16);
  localparam logic [WW-1:0] LAST_IDX = WW'(NUM_WORDS);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic cs_hist;
  logic sck_hist;
  logic cs_s;
  logic sck_s;
  logic cs_fall;
  logic cs_rise;
  logic sck_fall;
  logic sck_rise;

  logic [NUM_WORDS*16-1:0] snap;
  logic [15:0] shreg;
  logic [3:0] bit_idx;
  logic [WW-1:0] word_idx;
  logic [WW-1:0] next_idx;
  logic [15:0] next_word;
  logic [15:0] bit_cnt;

  // Synchronisers reset low so a frame already in progress at reset
  // release is never mistaken for a fresh CS falling edge.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cs_sync  <= '0;
      sck_sync <= '0;
      cs_hist  <= 1'b0;
      sck_hist <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], i_SPI_CS};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], i_SPI_Clock};
      cs_hist  <= cs_s;
      sck_hist <= sck_s;
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_hist & ~cs_s;
  assign cs_rise  = ~cs_hist & cs_s;
  assign sck_fall = sck_hist & ~sck_s;
  assign sck_rise = ~sck_hist & sck_s;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= WAIT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_IDLE: if (cs_s && cs_hist) state_d = IDLE;
      IDLE:      if (cs_fall) state_d = SHIFT;
      SHIFT:     if (cs_rise) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = WAIT_IDLE;
    endcase
  end

  always_comb begin
    o_Busy        = (state_q == SHIFT);
    o_SPI_Data    = (state_q == SHIFT) & shreg[15];
    o_Frame_Done  = (state_q == DONE);
    o_Short_Frame = (state_q == DONE) && (bit_cnt != FULL_BITS);
    o_Bit_Count   = bit_cnt;
  end

  // Word following the current one; zero once the snapshot is exhausted.
  assign next_idx = word_idx + 1'b1;

  always_comb begin
    next_word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (int'(next_idx) == k) next_word = snap[k*16 +: 16];
    end
  end

  // A CS rise in the same cycle as an SCK edge discards the SCK edge.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      snap     <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      word_idx <= '0;
      bit_cnt  <= '0;
    end else if (state_q == IDLE && cs_fall) begin
      snap     <= i_Status;
      shreg    <= i_Status[15:0];
      bit_idx  <= '0;
      word_idx <= '0;
      bit_cnt  <= '0;
    end else if (state_q == SHIFT && !cs_rise) begin
      if (sck_rise && bit_cnt != 16'hFFFF) begin
        bit_cnt <= bit_cnt + 16'd1;
      end
      if (sck_fall) begin
        if (bit_idx == 4'd15) begin
          bit_idx <= '0;
          shreg   <= next_word;
          if (word_idx != LAST_IDX) word_idx <= next_idx;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          shreg   <= {shreg[14:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_status_tx.sv
// Bench for spi_status_tx: an MCU model drives CS/SCK, samples MISO on SCK
// rising edges and compares against the status snapshot taken at CS fall.
module tb_spi_status_tx;

  localparam int NW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs = 1'b1;
  logic sck = 1'b0;
  logic [NW*16-1:0] status;
  logic miso;
  logic busy;
  logic done;
  logic short_f;
  logic [15:0] bcnt;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [15:0] cnt_cap = '0;
  logic short_cap = 1'b0;

  spi_status_tx #(.NUM_WORDS(NW), .SYNC_STAGES(2)) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_SPI_CS     (cs),
    .i_SPI_Clock  (sck),
    .i_Status     (status),
    .o_SPI_Data   (miso),
    .o_Busy       (busy),
    .o_Frame_Done (done),
    .o_Short_Frame(short_f),
    .o_Bit_Count  (bcnt)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (done) begin
      done_cnt  = done_cnt + 1;
      cnt_cap   = bcnt;
      short_cap = short_f;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bit i of the frame as the MCU should see it: word i/16, MSB first,
  // zero past the end of the snapshot.
  function automatic logic exp_bit(input logic [NW*16-1:0] s, input int i);
    if (i >= NW * 16) return 1'b0;
    return s[(i / 16) * 16 + 15 - (i % 16)];
  endfunction

  task automatic run_frame(input string tag, input int nbits,
                           input int chg_at, input logic [15:0] chg_word);
    logic [NW*16-1:0] snap;
    logic [15:0] got;
    logic [15:0] exp;
    int h;
    snap = status;
    done_cnt = 0;
    cs = 1'b0;
    wait_clk(6);
    got = '0;
    exp = '0;
    for (int i = 0; i < nbits; i++) begin
      h = $urandom_range(5, 8);
      sck = 1'b1;
      got = {got[14:0], miso};
      exp = {exp[14:0], exp_bit(snap, i)};
      if (i == nbits / 2) check({tag, ":busy"}, busy, 1);
      if (i % 16 == 15 || i == nbits - 1) begin
        check({tag, ":word"}, got, exp);
        got = '0;
        exp = '0;
      end
      if (i == chg_at) status[15:0] = chg_word;
      wait_clk(h);
      sck = 1'b0;
      wait_clk(h);
    end
    cs = 1'b1;
    wait_clk(12);
    check({tag, ":done_pulses"}, done_cnt, 1);
    check({tag, ":bit_count"}, cnt_cap, nbits);
    check({tag, ":short"}, short_cap, (nbits != NW * 16));
    check({tag, ":idle_busy"}, busy, 0);
    check({tag, ":idle_miso"}, miso, 0);
    wait_clk(4);
  endtask

  initial begin
    int act;
    status = {16'h1234, 16'hFFFF, 16'h8000, 16'h0001, 16'hA5C3};

    wait_clk(3);
    check("rst_miso", miso, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_short", short_f, 0);
    check("rst_count", bcnt, 0);
    rst = 1'b0;
    wait_clk(6);

    run_frame("full", 80, -1, 16'h0);
    run_frame("snap", 80, 3, 16'h5A3C);
    run_frame("snap_next", 80, -1, 16'h0);
    run_frame("short37", 37, -1, 16'h0);
    run_frame("restart", 80, -1, 16'h0);
    run_frame("long96", 96, -1, 16'h0);

    // Reset pulse in the middle of a frame with CS held low.
    cs = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 20; i++) begin
      sck = 1'b1;
      wait_clk(6);
      sck = 1'b0;
      wait_clk(6);
    end
    rst = 1'b1;
    wait_clk(1);
    check("midrst_miso", miso, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_count", bcnt, 0);
    rst = 1'b0;
    done_cnt = 0;
    act = 0;
    for (int i = 0; i < 5; i++) begin
      sck = 1'b1;
      repeat (6) begin
        @(negedge clk);
        if (miso !== 1'b0 || busy !== 1'b0) act++;
      end
      sck = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (miso !== 1'b0 || busy !== 1'b0) act++;
      end
    end
    check("midrst_quiet", act, 0);
    cs = 1'b1;
    wait_clk(20);
    check("midrst_no_done", done_cnt, 0);
    run_frame("after_rst", 80, -1, 16'h0);

    // SCK activity with CS high must not reach MISO.
    act = 0;
    for (int i = 0; i < 10; i++) begin
      sck = ~sck;
      repeat (6) begin
        @(negedge clk);
        if (miso !== 1'b0 || busy !== 1'b0 || done !== 1'b0) act++;
      end
    end
    sck = 1'b0;
    wait_clk(6);
    check("cs_high_quiet", act, 0);
    run_frame("empty", 0, -1, 16'h0);

    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < NW; k++) status[k*16 +: 16] = 16'($urandom);
      run_frame("rand", $urandom_range(1, 100), $urandom_range(0, 40),
                16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
